mdu: RTL



---
 rtl/mdu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched on an accepted Start; HI/LO update once, when Busy falls.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_e           state;
    op_e              op_in;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               div_signed;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   uquot;
    logic [WIDTH-1:0]   urem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               is_mult;
    logic               div_ok;

    always_comb begin
        op_in = op_e'(Op);
    end

    // Sign- or zero-extend to 2*WIDTH so one unsigned multiply gives the
    // full two's-complement product for both mult and multu.
    always_comb begin
        ext_a = '0;
        ext_b = '0;
        prod  = '0;
        if (op_q == OP_MULT) begin
            ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ext_a = {{WIDTH{1'b0}}, a_q};
            ext_b = {{WIDTH{1'b0}}, b_q};
        end
        prod = ext_a * ext_b;
    end

    // Signed divide via magnitudes; min / -1 falls out as quotient = min, remainder 0.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        neg_a      = div_signed & a_q[WIDTH-1];
        neg_b      = div_signed & b_q[WIDTH-1];
        mag_a      = neg_a ? (~a_q + 1'b1) : a_q;
        mag_b      = neg_b ? (~b_q + 1'b1) : b_q;
        div_b      = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uquot      = mag_a / div_b;
        urem       = mag_a % div_b;
        quot       = (neg_a ^ neg_b) ? (~uquot + 1'b1) : uquot;
        rem        = neg_a ? (~urem + 1'b1) : urem;
    end

    always_comb begin
        is_mult = (op_q == OP_MULT) || (op_q == OP_MULTU);
        div_ok  = (b_q != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (op_in)
                            OP_MULT, OP_MULTU: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= op_in;
                                cnt   <= CW'(MULT_CYCLES);
                                state <= RUN;
                                Busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= op_in;
                                cnt   <= CW'(DIV_CYCLES);
                                state <= RUN;
                                Busy  <= 1'b1;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        if (is_mult) begin
                            HI <= prod[2*WIDTH-1:WIDTH];
                            LO <= prod[WIDTH-1:0];
                        end else if (div_ok) begin
                            HI <= rem;
                            LO <= quot;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
